// File: rtl/tdm_demux2.sv
// Receive side of a 2:1 TDM link: locks to frame sync, splits slot 0/1 into registered channels.
// Optional even-parity beat checking is enabled by defining TDM_DEMUX_PARITY_CHECK_EN.
module tdm_demux2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sync,
`ifdef TDM_DEMUX_PARITY_CHECK_EN
  input  logic             in_parity,
  output logic             par_err,
`endif
  input  logic             err_clr,
  output logic [WIDTH-1:0] out0,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_exp_slot;
  logic             w_exp_nx;
  logic [WIDTH-1:0] r_out0;
  logic [WIDTH-1:0] r_out1;
  logic             r_out0_valid;
  logic             r_out1_valid;
  logic             r_locked;
  logic             r_sync_err;
  logic             w_cap0;
  logic             w_cap1;
  logic             w_serr_set;
  logic             w_par_ok;

`ifdef TDM_DEMUX_PARITY_CHECK_EN
  logic r_par_err;
  logic w_perr_set;

  // Even parity: data bits plus parity bit carry an even number of ones.
  assign w_par_ok   = (in_parity == (^in_data));
  assign w_perr_set = in_valid & ~w_par_ok;
  assign par_err    = r_par_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (w_perr_set) begin
      r_par_err <= 1'b1;
    end else if (err_clr) begin
      r_par_err <= 1'b0;
    end
  end
`else
  assign w_par_ok = 1'b1;
`endif

  // Next-state and capture decode; a parity-failed beat still steers the slot pointer.
  always_comb begin
    w_state_nx = r_state;
    w_exp_nx   = r_exp_slot;
    w_cap0     = 1'b0;
    w_cap1     = 1'b0;
    w_serr_set = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (in_sync) begin
            w_cap0     = w_par_ok;
            w_state_nx = ST_LOCK;
            w_exp_nx   = 1'b1;
          end
        end
        ST_LOCK: begin
          if (!r_exp_slot) begin
            if (in_sync) begin
              w_cap0   = w_par_ok;
              w_exp_nx = 1'b1;
            end else begin
              w_serr_set = w_par_ok;
              w_state_nx = ST_HUNT;
              w_exp_nx   = 1'b0;
            end
          end else begin
            if (in_sync) begin
              // Early sync: resynchronise on this beat as the new slot 0.
              w_serr_set = w_par_ok;
              w_cap0     = w_par_ok;
              w_exp_nx   = 1'b1;
            end else begin
              w_cap1   = w_par_ok;
              w_exp_nx = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_exp_slot <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_exp_slot <= w_exp_nx;
      r_locked   <= (w_state_nx == ST_LOCK);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out0       <= '0;
      r_out1       <= '0;
      r_out0_valid <= 1'b0;
      r_out1_valid <= 1'b0;
    end else begin
      r_out0_valid <= w_cap0;
      r_out1_valid <= w_cap1;
      if (w_cap0) begin
        r_out0 <= in_data;
      end
      if (w_cap1) begin
        r_out1 <= in_data;
      end
    end
  end

  // Sticky error: a new error wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_err <= 1'b0;
    end else if (w_serr_set) begin
      r_sync_err <= 1'b1;
    end else if (err_clr) begin
      r_sync_err <= 1'b0;
    end
  end

  assign out0       = r_out0;
  assign out1       = r_out1;
  assign out0_valid = r_out0_valid;
  assign out1_valid = r_out1_valid;
  assign locked     = r_locked;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux2.sv
// Scoreboard bench for tdm_demux2: directed beats push expected channel samples, a monitor pops on valid pulses.
module tb_tdm_demux2;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sync;
  logic             err_clr;
  logic [WIDTH-1:0] out0;
  logic             out0_valid;
  logic [WIDTH-1:0] out1;
  logic             out1_valid;
  logic             locked;
  logic             sync_err;
`ifdef TDM_DEMUX_PARITY_CHECK_EN
  logic             in_parity;
  logic             par_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  tdm_demux2 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
`ifdef TDM_DEMUX_PARITY_CHECK_EN
    .in_parity (in_parity),
    .par_err   (par_err),
`endif
    .err_clr   (err_clr),
    .out0      (out0),
    .out0_valid(out0_valid),
    .out1      (out1),
    .out1_valid(out1_valid),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_valid && out1_valid) begin
        chk("both_valid", 32'(out0_valid & out1_valid), 32'd0);
      end
      if (out0_valid) begin
        if (q0.size() == 0) chk("spurious_out0_valid", 32'd1, 32'd0);
        else chk("out0_data", 32'(out0), 32'(q0.pop_front()));
      end
      if (out1_valid) begin
        if (q1.size() == 0) chk("spurious_out1_valid", 32'd1, 32'd0);
        else chk("out1_data", 32'(out1), 32'(q1.pop_front()));
      end
    end
  end

  // One beat per call, starting and ending at a falling edge; dest 0=dropped, 1=out0, 2=out1.
  task automatic beat(input logic [WIDTH-1:0] d, input logic s, input logic clr,
                      input logic bad_par, input int dest);
    if (dest == 1) q0.push_back(d);
    if (dest == 2) q1.push_back(d);
    in_data  = d;
    in_sync  = s;
    in_valid = 1'b1;
    err_clr  = clr;
`ifdef TDM_DEMUX_PARITY_CHECK_EN
    in_parity = (^d) ^ bad_par;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    in_sync  = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    err_clr  = 1'b0;
`ifdef TDM_DEMUX_PARITY_CHECK_EN
    in_parity = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_out0", 32'(out0), 32'h0);
    chk("rst_out1", 32'(out1), 32'h0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_valids", 32'({out0_valid, out1_valid}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back frames
    beat(8'h11, 1'b1, 1'b0, 1'b0, 1);
    chk("lock_after_first", 32'(locked), 32'd1);
    beat(8'h22, 1'b0, 1'b0, 1'b0, 2);
    beat(8'h33, 1'b1, 1'b0, 1'b0, 1);
    beat(8'h44, 1'b0, 1'b0, 1'b0, 2);
    chk("frames_out0", 32'(out0), 32'h33);
    chk("frames_out1", 32'(out1), 32'h44);
    chk("frames_sync_err", 32'(sync_err), 32'd0);
    gap(2);
    chk("hold_out0", 32'(out0), 32'h33);
    chk("hold_valids", 32'({out0_valid, out1_valid}), 32'd0);

    // Missing sync while expecting slot 0
    beat(8'h66, 1'b0, 1'b0, 1'b0, 0);
    chk("miss_sync_err", 32'(sync_err), 32'd1);
    chk("miss_locked", 32'(locked), 32'd0);
    chk("miss_out1_kept", 32'(out1), 32'h44);
    chk("miss_out0_kept", 32'(out0), 32'h33);
    clear_err();
    chk("clr_sync_err", 32'(sync_err), 32'd0);

    // Hunting: unsynced beats discarded
    beat(8'hAA, 1'b0, 1'b0, 1'b0, 0);
    beat(8'hBB, 1'b0, 1'b0, 1'b0, 0);
    chk("hunt_locked", 32'(locked), 32'd0);
    chk("hunt_out0", 32'(out0), 32'h33);
    beat(8'h55, 1'b1, 1'b0, 1'b0, 1);
    chk("relock_locked", 32'(locked), 32'd1);
    chk("relock_out0", 32'(out0), 32'h55);

    // Early sync while expecting slot 1
    beat(8'h77, 1'b1, 1'b0, 1'b0, 1);
    chk("early_sync_err", 32'(sync_err), 32'd1);
    chk("early_out0", 32'(out0), 32'h77);
    chk("early_locked", 32'(locked), 32'd1);
    beat(8'h88, 1'b0, 1'b0, 1'b0, 2);
    chk("early_out1", 32'(out1), 32'h88);

    // Error and clear in the same cycle: set wins
    beat(8'h99, 1'b0, 1'b1, 1'b0, 0);
    chk("setdom_sync_err", 32'(sync_err), 32'd1);
    chk("setdom_locked", 32'(locked), 32'd0);
    clear_err();
    chk("setdom_clr", 32'(sync_err), 32'd0);

    // Gapped frames
    gap(3);
    beat(8'hA1, 1'b1, 1'b0, 1'b0, 1);
    gap(3);
    chk("gap_out0", 32'(out0), 32'hA1);
    beat(8'hA2, 1'b0, 1'b0, 1'b0, 2);
    gap(3);
    beat(8'hA3, 1'b1, 1'b0, 1'b0, 1);
    gap(3);
    beat(8'hA4, 1'b0, 1'b0, 1'b0, 2);
    chk("gap_out1", 32'(out1), 32'hA4);
    chk("gap_out0_b", 32'(out0), 32'hA3);
    chk("gap_sync_err", 32'(sync_err), 32'd0);

    // Reset after the slot-0 beat of a frame
    beat(8'hC1, 1'b1, 1'b0, 1'b0, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out0", 32'(out0), 32'h0);
    chk("midrst_out1", 32'(out1), 32'h0);
    chk("midrst_valids", 32'({out0_valid, out1_valid}), 32'd0);
    chk("midrst_locked", 32'(locked), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    beat(8'hC2, 1'b0, 1'b0, 1'b0, 0);
    chk("postrst_locked", 32'(locked), 32'd0);
    chk("postrst_out1", 32'(out1), 32'h0);
    chk("postrst_sync_err", 32'(sync_err), 32'd0);

`ifdef TDM_DEMUX_PARITY_CHECK_EN
    // Bad parity on slot 1: dropped, pointer still advances to slot 0
    beat(8'h90, 1'b1, 1'b0, 1'b0, 1);
    beat(8'h91, 1'b0, 1'b0, 1'b1, 0);
    chk("par_err_set", 32'(par_err), 32'd1);
    chk("par_out1_kept", 32'(out1), 32'h0);
    beat(8'h92, 1'b1, 1'b0, 1'b0, 1);
    chk("par_next_slot0", 32'(out0), 32'h92);
    chk("par_no_sync_err", 32'(sync_err), 32'd0);
    chk("par_locked", 32'(locked), 32'd1);
    clear_err();
    chk("par_err_clr", 32'(par_err), 32'd0);
`endif

    gap(3);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux2.md
Name: tdm_demux2

Overview:
- Receive end of the 2:1 channel-multiplexing path. A single link carries samples from two sources interleaved in time: slot 0 (w0 source), then slot 1 (w1 source).
- This block locks onto the frame sync and splits the stream back into two registered channel outputs, each with its own valid strobe.
- It detects frame misalignment and reports it with a sticky error flag.

Parameters:
- WIDTH, 8, bit width of each sample on the link and on each channel output (legal range 1..32).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  link sample.
- in_valid  input  1  in_data holds a new sample this cycle (one beat per cycle max).
- in_sync  input  1  qualifies with in_valid; 1 marks the slot-0 beat of a frame.
- err_clr  input  1  synchronous clear of the sticky error flags.
- out0  output  WIDTH  last accepted slot-0 sample.
- out0_valid  output  1  one-cycle pulse: out0 updated this cycle.
- out1  output  WIDTH  last accepted slot-1 sample.
- out1_valid  output  1  one-cycle pulse: out1 updated this cycle.
- locked  output  1  1 while aligned to the frame.
- sync_err  output  1  sticky frame-misalignment flag.

Behaviour:
- Reset (async assert, sync release): state=HUNT, expected slot=0.
  - out0, out1 = 0.
  - out0_valid, out1_valid, locked, sync_err = 0.
- States: HUNT, LOCK. The locked output equals (state==LOCK) and is registered.
- HUNT:
  - Beats with in_sync=0 are discarded; no valid pulse.
  - A beat with in_valid & in_sync: capture to out0, pulse out0_valid next cycle, go to LOCK, set expected slot=1.
- LOCK, expected slot 1:
  - Beat with in_sync=0: capture to out1, pulse out1_valid, set expected slot=0.
  - Beat with in_sync=1 (early sync): set sync_err, treat as slot 0, capture to out0, pulse out0_valid, expected slot=1, stay in LOCK.
- LOCK, expected slot 0:
  - Beat with in_sync=1: capture to out0, pulse out0_valid, set expected slot=1.
  - Beat with in_sync=0 (missing sync): set sync_err, discard the beat, go to HUNT, expected slot=0.
- Cycles with in_valid=0 change nothing. Gaps between beats of any length are allowed, and the slot pointer does not advance during a gap.
- Latency: a beat accepted on cycle N updates outX and raises outX_valid on cycle N+1.
  - Valid pulses last exactly one cycle.
  - out0_valid and out1_valid are never high together.
  - outX holds its value between updates.
- sync_err:
  - Set-dominant: if err_clr and a new error occur in the same cycle, sync_err stays 1.
  - err_clr alone clears it the next cycle.
  - err_clr does not affect state or data.
- Reset mid-frame returns all state and outputs to reset values. A half-received frame is lost, and no pulse is emitted after reset.
- No backpressure: the block accepts every valid beat.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_CHECK_EN.
- Defined:
  - Extra input port in_parity (1 bit), carrying even parity over in_data.
  - Extra output port par_err (1 bit, sticky, reset 0).
  - A beat whose parity mismatches is dropped: no capture, no valid pulse, no error check on in_sync.
  - The slot pointer and state still advance as if the beat had been accepted.
  - par_err is set, with the same set-dominant clear by err_clr as sync_err.
- Undefined: neither port exists and all beats are accepted as described.

Test Plan:
- Reset, then frames (sync=1, 0x11), (sync=0, 0x22), (sync=1, 0x33), (sync=0, 0x44) back-to-back.
  - Expected: locked=1 from the cycle after the first beat.
  - out0=0x11 then 0x33, out1=0x22 then 0x44, each with a single one-cycle valid pulse at N+1; sync_err=0.
- In HUNT, beats 0xAA and 0xBB with sync=0, then sync=1 0x55.
  - Expected: no pulses for 0xAA/0xBB; out0=0x55 with out0_valid; locked=1.
- In LOCK expecting slot 0, send sync=0 0x66.
  - Expected: no capture, sync_err=1, locked=0.
  - Then err_clr=1 for one cycle: sync_err=0.
- In LOCK expecting slot 1, send sync=1 0x77.
  - Expected: sync_err=1, out0=0x77, out0_valid pulse; next beat sync=0 0x88 gives out1=0x88.
- Frame with 3-cycle gaps between beats.
  - Expected: correct slot routing, no spurious pulses during the gaps.
- Assert rst mid-frame, after the slot-0 beat.
  - Expected: all outputs 0 immediately; the following sync=0 beat is discarded.
  - With TDM_DEMUX_PARITY_CHECK_EN: a wrong-parity beat on slot 1 produces no out1_valid and sets par_err=1.
